// File: rtl/diagv2_test_sequencer_pkg.sv
// Shared constants for the diagv2 regression sequencer: bus width, FSM encoding, timeout code.
package diagv2_test_sequencer_pkg;

   localparam int DataBusBits = 32;

   localparam int ST_W = 3;
   localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [ST_W-1:0] ST_LOAD   = 3'd1;
   localparam logic [ST_W-1:0] ST_HOLD   = 3'd2;
   localparam logic [ST_W-1:0] ST_RUN    = 3'd3;
   localparam logic [ST_W-1:0] ST_RECORD = 3'd4;
   localparam logic [ST_W-1:0] ST_DONE   = 3'd5;

   // Status code recorded for a test that never reached ECALL.
   localparam logic [DataBusBits-1:0] TIMEOUT_CODE = '1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/diagv2_test_sequencer_if.sv
// Sequencer <-> core/loader/status bundle; master = sequencer, slave = surrounding system.
interface diagv2_test_sequencer_if #(
   parameter int IDX_W = 6,
   parameter int CNT_W = 6
);
   import diagv2_test_sequencer_pkg::*;

   logic                   start;
   logic                   ecall;
   logic [DataBusBits-1:0] statusCode;
   logic                   load_req;
   logic [IDX_W-1:0]       load_idx;
   logic                   load_ack;
   logic                   core_reset;
   logic [IDX_W-1:0]       test_idx;
   logic [CNT_W-1:0]       passed;
   logic [CNT_W-1:0]       failed;
   logic                   fail_seen;
   logic [IDX_W-1:0]       first_fail_idx;
   logic [DataBusBits-1:0] first_fail_code;
   logic                   timeout;
   logic                   done;

   modport master (
      input  start, ecall, statusCode, load_ack,
      output load_req, load_idx, core_reset, test_idx, passed, failed,
             fail_seen, first_fail_idx, first_fail_code, timeout, done
   );

   modport slave (
      output start, ecall, statusCode, load_ack,
      input  load_req, load_idx, core_reset, test_idx, passed, failed,
             fail_seen, first_fail_idx, first_fail_code, timeout, done
   );

endinterface

// File: rtl/diagv2_test_sequencer_seq_timer.sv
// Loadable down-counter; expired while the count sits at zero.
module diagv2_seq_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expired
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= value;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign expired = (r_cnt == '0);

endmodule

// File: rtl/diagv2_test_sequencer.sv
// Regression sequencer: load image, hold core reset, run to ECALL, score, advance.
// Optional RUN timeout enabled by defining DIAGV2_SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LOAD   | loader request out for image test_idx
// HOLD   | core kept in reset for RESET_CYCLES after the load
// RUN    | core running, waiting for ecall (or timeout)
// RECORD | score captured code, pick next test or finish
// DONE   | campaign complete, start begins a new one
module diagv2_test_sequencer
   import diagv2_test_sequencer_pkg::*;
#(
   parameter int TESTS          = 50,
   parameter int RESET_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int IDX_W          = $clog2(TESTS),
   parameter int CNT_W          = $clog2(TESTS + 1)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   diagv2_test_sequencer_if.master bus
);

`ifdef DIAGV2_SEQ_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif
   localparam int TMR_MAX = max_int(RESET_CYCLES, TIMEOUT_EN ? TIMEOUT_CYCLES : 0);
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   logic [ST_W-1:0]        r_state;
   logic                   r_load_req;
   logic                   r_core_reset;
   logic                   r_done;
   logic [IDX_W-1:0]       r_test_idx;
   logic [CNT_W-1:0]       r_passed;
   logic [CNT_W-1:0]       r_failed;
   logic                   r_fail_seen;
   logic [IDX_W-1:0]       r_ff_idx;
   logic [DataBusBits-1:0] r_ff_code;
   logic                   r_timeout;
   logic [DataBusBits-1:0] r_code;

   logic [ST_W-1:0]        w_state_nxt;
   logic                   w_tmr_load;
   logic [TMR_W-1:0]       w_tmr_value;
   logic                   w_expired;
   logic                   w_to_hit;
   logic                   w_start_ok;

   diagv2_seq_timer #(.W(TMR_W)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (w_tmr_load),
      .value   (w_tmr_value),
      .expired (w_expired)
   );

   assign w_start_ok = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_load  = 1'b0;
      w_tmr_value = '0;
      w_to_hit    = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: if (bus.start) w_state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (bus.load_ack) begin
               w_state_nxt = ST_HOLD;
               w_tmr_load  = 1'b1;
               w_tmr_value = TMR_W'(RESET_CYCLES - 1);
            end
         end
         ST_HOLD: begin
            if (w_expired) begin
               w_state_nxt = ST_RUN;
`ifdef DIAGV2_SEQ_TIMEOUT_EN
               w_tmr_load  = 1'b1;
               w_tmr_value = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
            end
         end
         ST_RUN: begin
            // ecall has priority over a coincident timeout
            if (bus.ecall) begin
               w_state_nxt = ST_RECORD;
`ifdef DIAGV2_SEQ_TIMEOUT_EN
            end else if (w_expired) begin
               w_state_nxt = ST_RECORD;
               w_to_hit    = 1'b1;
`endif
            end
         end
         ST_RECORD: w_state_nxt = (r_test_idx == IDX_W'(TESTS - 1)) ? ST_DONE : ST_LOAD;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_load_req   <= 1'b0;
         r_core_reset <= 1'b1;
         r_done       <= 1'b0;
         r_test_idx   <= '0;
         r_passed     <= '0;
         r_failed     <= '0;
         r_fail_seen  <= 1'b0;
         r_ff_idx     <= '0;
         r_ff_code    <= '0;
         r_timeout    <= 1'b0;
         r_code       <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_load_req   <= (w_state_nxt == ST_LOAD);
         r_core_reset <= (w_state_nxt != ST_RUN);
         r_done       <= (w_state_nxt == ST_DONE);

         if (r_state == ST_RUN && w_state_nxt == ST_RECORD) begin
            r_code <= w_to_hit ? TIMEOUT_CODE : bus.statusCode;
         end
         if (w_to_hit) r_timeout <= 1'b1;

         if (w_start_ok) begin
            r_test_idx  <= '0;
            r_passed    <= '0;
            r_failed    <= '0;
            r_fail_seen <= 1'b0;
            r_ff_idx    <= '0;
            r_ff_code   <= '0;
            r_timeout   <= 1'b0;
         end

         if (r_state == ST_RECORD) begin
            if (r_code == '0) begin
               r_passed <= r_passed + 1'b1;
            end else begin
               r_failed <= r_failed + 1'b1;
               if (!r_fail_seen) begin
                  r_fail_seen <= 1'b1;
                  r_ff_idx    <= r_test_idx;
                  r_ff_code   <= r_code;
               end
            end
            if (w_state_nxt == ST_LOAD) r_test_idx <= r_test_idx + 1'b1;
         end
      end
   end

   assign bus.load_req        = r_load_req;
   assign bus.load_idx        = r_test_idx;
   assign bus.core_reset      = r_core_reset;
   assign bus.test_idx        = r_test_idx;
   assign bus.passed          = r_passed;
   assign bus.failed          = r_failed;
   assign bus.fail_seen       = r_fail_seen;
   assign bus.first_fail_idx  = r_ff_idx;
   assign bus.first_fail_code = r_ff_code;
   assign bus.timeout         = r_timeout;
   assign bus.done            = r_done;

endmodule

// File: tb/tb_diagv2_test_sequencer.sv
// Scoreboard bench for diagv2_test_sequencer; timeout scenario compiled in with DIAGV2_SEQ_TIMEOUT_EN.
module tb_diagv2_test_sequencer;
   import diagv2_test_sequencer_pkg::*;

   localparam int TESTS          = 3;
   localparam int RESET_CYCLES   = 2;
   localparam int TIMEOUT_CYCLES = 50;
   localparam int IDX_W          = $clog2(TESTS);
   localparam int CNT_W          = $clog2(TESTS + 1);

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   diagv2_test_sequencer_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

   diagv2_test_sequencer #(
      .TESTS(TESTS), .RESET_CYCLES(RESET_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .IDX_W(IDX_W), .CNT_W(CNT_W)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      int          passed;
      int          failed;
      bit          seen;
      int          ffi;
      logic [31:0] ffc;
      bit          to;
      bit          done;
      int          tidx;
   } exp_t;

   exp_t q[$];
   int n_tests = 0;
   int n_fail  = 0;

   // reference model: campaign-level tallies
   int          m_pass, m_fail, m_ffi;
   bit          m_seen, m_to;
   logic [31:0] m_ffc;
   bit          mon_en = 1'b0;
   int          prev_sum = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_clear();
      m_pass = 0; m_fail = 0; m_ffi = 0; m_seen = 0; m_to = 0; m_ffc = '0;
   endtask

   task automatic model_score(input int idx, input logic [31:0] code, input bit to);
      exp_t e;
      if (code == 0) m_pass++;
      else begin
         m_fail++;
         if (!m_seen) begin m_seen = 1; m_ffi = idx; m_ffc = code; end
      end
      if (to) m_to = 1;
      e.passed = m_pass; e.failed = m_fail; e.seen = m_seen; e.ffi = m_ffi;
      e.ffc = m_ffc; e.to = m_to; e.done = (idx == TESTS - 1);
      e.tidx = (idx == TESTS - 1) ? idx : idx + 1;
      q.push_back(e);
   endtask

   // monitor: any change of the score total is a scored test
   always @(negedge clk) begin
      int   sum;
      exp_t e;
      sum = int'(bus.passed) + int'(bus.failed);
      if (mon_en && sum != prev_sum && sum != 0) begin
         if (q.size() == 0) chk("sb_unexpected_score", 64'(sum), 64'(prev_sum));
         else begin
            e = q.pop_front();
            chk("sb_passed", bus.passed, e.passed);
            chk("sb_failed", bus.failed, e.failed);
            chk("sb_fail_seen", bus.fail_seen, e.seen);
            chk("sb_first_fail_idx", bus.first_fail_idx, e.ffi);
            chk("sb_first_fail_code", bus.first_fail_code, e.ffc);
            chk("sb_timeout", bus.timeout, e.to);
            chk("sb_done", bus.done, e.done);
            chk("sb_test_idx", bus.test_idx, e.tidx);
         end
      end
      prev_sum = sum;
   end

   task automatic start_campaign();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      model_clear();
      chk("start_load_req", bus.load_req, 1);
      chk("start_test_idx", bus.test_idx, 0);
      chk("start_cleared", {bus.passed, bus.failed, bus.fail_seen, bus.timeout, bus.done}, 0);
   endtask

   task automatic run_test(input int idx, input int ack_dly, input logic [31:0] code,
                           input int hold, input int gap, input bit to,
                           input bit pulse_start, input bit abort);
      int n = 0;
      bit ok;
      while (!bus.load_req && n < 100) begin @(negedge clk); n++; end
      chk("load_req_seen", bus.load_req, 1);
      chk("load_idx", bus.load_idx, idx);
      ok = 1;
      for (int d = 0; d < ack_dly; d++) begin
         ok &= bus.load_req && bus.core_reset;
         bus.ecall = 1'($urandom_range(0, 1));
         bus.statusCode = $urandom;
         @(negedge clk);
      end
      chk("load_wait_held", ok, 1);
      bus.ecall    = 1'b0;
      bus.load_ack = 1'b1;
      @(negedge clk);
      bus.load_ack = 1'b0;
      ok = 1;
      for (int i = 0; i < RESET_CYCLES; i++) begin
         ok &= bus.core_reset && !bus.load_req;
         @(negedge clk);
      end
      chk("hold_len", ok, 1);
      chk("run_entry_core_reset", bus.core_reset, 0);
      if (abort) return;
`ifdef DIAGV2_SEQ_TIMEOUT_EN
      if (to) begin
         model_score(idx, '1, 1'b1);
         ok = 1;
         for (int c = 1; c < TIMEOUT_CYCLES; c++) begin
            @(negedge clk);
            ok &= !bus.core_reset;
         end
         chk("to_run_len", ok, 1);
         @(negedge clk);
         chk("to_record_core_reset", bus.core_reset, 1);
         @(negedge clk);
         chk("to_next_load_req", bus.load_req, 1);
         return;
      end
`endif
      ok = 1;
      for (int g = 0; g < gap; g++) begin
         bus.start    = pulse_start && (g == 0);
         bus.load_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         ok &= !bus.core_reset;
      end
      bus.start    = 1'b0;
      bus.load_ack = 1'b0;
      chk("run_held", ok, 1);
      model_score(idx, code, 1'b0);
      bus.ecall      = 1'b1;
      bus.statusCode = code;
      @(negedge clk);
      if (hold <= 1) bus.ecall = 1'b0;
      chk("record_core_reset", bus.core_reset, 1);
      @(negedge clk);
      if (hold <= 2) bus.ecall = 1'b0;
      if (idx == TESTS - 1) chk("done_after_last", bus.done, 1);
      else chk("next_load_req", bus.load_req, 1);
      for (int h = 2; h < hold; h++) @(negedge clk);
      bus.ecall = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] c;
      bus.start = 1'b0; bus.ecall = 1'b0; bus.statusCode = '0; bus.load_ack = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("rst_core_reset", bus.core_reset, 1);
      chk("rst_load_req", bus.load_req, 0);
      chk("rst_flags", {bus.done, bus.timeout, bus.fail_seen}, 0);
      chk("rst_counts", {bus.passed, bus.failed, bus.test_idx, bus.first_fail_idx}, 0);
      chk("rst_ff_code", bus.first_fail_code, 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_no_load", bus.load_req, 0);
      mon_en = 1'b1;

      // all pass
      start_campaign();
      for (int i = 0; i < TESTS; i++)
         run_test(i, $urandom_range(0, 3), 0, 1, $urandom_range(1, 5), 0, 0, 0);

      // two failures, slow loader, long ecall with ignored start
      start_campaign();
      run_test(0, 0, 0, 1, 3, 0, 0, 0);
      run_test(1, 20, 7, 5, 2, 0, 1, 0);
      run_test(2, 1, 3, 1, 4, 0, 0, 0);

      // long RUN: timeout path or indefinite wait
      start_campaign();
`ifdef DIAGV2_SEQ_TIMEOUT_EN
      run_test(0, 1, 0, 1, 0, 1, 0, 0);
`else
      run_test(0, 1, 0, 1, TIMEOUT_CYCLES + 10, 0, 0, 0);
`endif
      run_test(1, 0, 5, 2, 2, 0, 0, 0);
      run_test(2, 2, 0, 1, 1, 0, 0, 0);

      // randomized campaigns
      for (int r = 0; r < 3; r++) begin
         start_campaign();
         for (int i = 0; i < TESTS; i++) begin
            c = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
            run_test(i, $urandom_range(0, 4), c, $urandom_range(1, 4),
                     $urandom_range(1, 6), 0, 0, 0);
         end
      end

      // async reset in the middle of test 1
      start_campaign();
      run_test(0, 0, 0, 1, 2, 0, 0, 0);
      run_test(1, 1, 0, 1, 2, 0, 0, 1);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_core_reset", bus.core_reset, 1);
      chk("midrst_counts", {bus.passed, bus.failed, bus.test_idx}, 0);
      model_clear();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrst_idle", {bus.load_req, bus.core_reset, bus.done}, 3'b010);
      start_campaign();
      for (int i = 0; i < TESTS; i++)
         run_test(i, $urandom_range(0, 2), (i == 1) ? 32'd9 : 32'd0, 1, 2, 0, 0, 0);

      repeat (3) @(negedge clk);
      chk("sb_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
